tcp_tx_burst_datap: RTL and testbench

Parametrised TCP transmit segment engine with its own control FSM. It accepts a scheduler grant for one flow, reads that flow's TX/RX state, and emits up to `MAX_BURST` back-to-back segments in one grant. Segment sizes are limited by MSS, queued data and the peer's advertised window. It writes back the sequence number monotonically and returns a flag-clear command to the scheduler. It sits between the TX scheduler and the header-assembly/payload-fetch stage.

---
 rtl/tcp_tx_burst_datap.sv | 190 +++++++++++++++++++
 tb/tb_tcp_tx_burst_datap.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_burst_datap.sv
// rtl/tcp_tx_burst_datap.sv - TCP TX burst segment engine; TCP_TX_ZWP_EN enables the 1-byte zero-window probe
module tcp_tx_burst_datap #(
    parameter int FLOWID_W  = 8,
    parameter int PTR_W     = 16,
    parameter int SEQ_W     = 32,
    parameter int WIN_W     = 16,
    parameter int MSS       = 1460,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sched_req_val,
    output logic                sched_req_rdy,
    input  logic [FLOWID_W-1:0] sched_req_flowid,
    input  logic                sched_req_rt,
    input  logic                sched_req_ack,
    output logic                state_rd_req_val,
    output logic [FLOWID_W-1:0] state_rd_req_addr,
    input  logic [PTR_W:0]      state_rd_resp_tail,
    input  logic [SEQ_W-1:0]    state_rd_resp_seq,
    input  logic [SEQ_W-1:0]    state_rd_resp_acked,
    input  logic [SEQ_W-1:0]    state_rd_resp_their_ack,
    input  logic [WIN_W-1:0]    state_rd_resp_their_win,
    input  logic [WIN_W-1:0]    state_rd_resp_our_win,
    output logic                seq_wr_val,
    output logic [FLOWID_W-1:0] seq_wr_addr,
    output logic [SEQ_W-1:0]    seq_wr_data,
    output logic                pkt_val,
    input  logic                pkt_rdy,
    output logic [FLOWID_W-1:0] pkt_flowid,
    output logic [SEQ_W-1:0]    pkt_seq_num,
    output logic [SEQ_W-1:0]    pkt_ack_num,
    output logic [WIN_W-1:0]    pkt_win,
    output logic [7:0]          pkt_flags,
    output logic [PTR_W-1:0]    pkt_payload_addr,
    output logic [PTR_W:0]      pkt_payload_len,
    output logic                upd_val,
    output logic [FLOWID_W-1:0] upd_flowid,
    output logic                upd_rt_clear,
    output logic                upd_ack_clear,
    output logic                upd_data_clear
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [PTR_W:0]     MSS_LEN   = (PTR_W+1)'(MSS);
    localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(MAX_BURST);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    logic [2:0]          state, state_nx;
    logic                rdy_q;
    logic [FLOWID_W-1:0] flowid_q;
    logic                rt_q, ack_q;
    logic [CNT_W-1:0]    cnt_q, cnt_inc;
    logic [PTR_W:0]      tail_q, avail_q, avail_left_q, avail_rem;
    logic [SEQ_W-1:0]    acked_q, orig_seq_q, work_seq_q;
    logic [WIN_W-1:0]    their_win_q;

    logic                first;
    logic [PTR_W:0]      cur_tail;
    logic [SEQ_W-1:0]    cur_seq, cur_acked;
    logic [WIN_W-1:0]    cur_their_win;
    logic [SEQ_W-1:0]    next_seq, inflight, win_ext, room;
    logic [PTR_W:0]      avail, len_c;
    logic                skip, more, wb;

    // The first CALC pass sees the live read response; later passes use the registered copy.
    always_comb begin
        first         = (cnt_q == '0);
        cur_tail      = first ? state_rd_resp_tail      : tail_q;
        cur_seq       = first ? state_rd_resp_seq       : work_seq_q;
        cur_acked     = first ? state_rd_resp_acked     : acked_q;
        cur_their_win = first ? state_rd_resp_their_win : their_win_q;

        next_seq = rt_q ? cur_acked : cur_seq;
        avail    = cur_tail - next_seq[PTR_W:0];
        inflight = next_seq - cur_acked;
        win_ext  = SEQ_W'(cur_their_win);
        room     = (win_ext > inflight) ? (win_ext - inflight) : '0;
        len_c    = (room > SEQ_W'(avail)) ? avail : room[PTR_W:0];
        if (len_c > MSS_LEN)
            len_c = MSS_LEN;
`ifdef TCP_TX_ZWP_EN
        if ((cur_their_win == '0) && (inflight == '0) && (avail != '0))
            len_c = (PTR_W+1)'(1);
`endif
        skip = (len_c == '0) && !rt_q && (!ack_q || (cnt_q != '0));

        cnt_inc   = cnt_q + CNT_W'(1);
        avail_rem = avail_q - pkt_payload_len;
        more      = !rt_q && (pkt_payload_len != '0) && (cnt_inc < BURST_MAX) && (avail_rem != '0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (sched_req_val && rdy_q) state_nx = S_RD;
            S_RD:   state_nx = S_CALC;
            S_CALC: state_nx = skip ? S_WB : S_EMIT;
            S_EMIT: if (pkt_rdy) state_nx = more ? S_CALC : S_WB;
            S_WB:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            rdy_q            <= 1'b0;
            flowid_q         <= '0;
            rt_q             <= 1'b0;
            ack_q            <= 1'b0;
            cnt_q            <= '0;
            tail_q           <= '0;
            avail_q          <= '0;
            avail_left_q     <= '0;
            acked_q          <= '0;
            orig_seq_q       <= '0;
            work_seq_q       <= '0;
            their_win_q      <= '0;
            pkt_seq_num      <= '0;
            pkt_ack_num      <= '0;
            pkt_win          <= '0;
            pkt_flags        <= '0;
            pkt_payload_addr <= '0;
            pkt_payload_len  <= '0;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (sched_req_val && rdy_q) begin
                        flowid_q <= sched_req_flowid;
                        rt_q     <= sched_req_rt;
                        ack_q    <= sched_req_ack;
                        cnt_q    <= '0;
                    end
                end
                S_CALC: begin
                    if (first) begin
                        tail_q      <= state_rd_resp_tail;
                        acked_q     <= state_rd_resp_acked;
                        their_win_q <= state_rd_resp_their_win;
                        orig_seq_q  <= state_rd_resp_seq;
                        work_seq_q  <= state_rd_resp_seq;
                        pkt_ack_num <= state_rd_resp_their_ack;
                        pkt_win     <= state_rd_resp_our_win;
                    end
                    // Descriptor is frozen here so it stays stable across any EMIT stall.
                    pkt_seq_num      <= next_seq;
                    pkt_payload_addr <= next_seq[PTR_W-1:0];
                    pkt_payload_len  <= len_c;
                    pkt_flags        <= (len_c != '0) ? 8'h18 : 8'h10;
                    avail_q          <= avail;
                    avail_left_q     <= avail;
                end
                S_EMIT: begin
                    if (pkt_rdy) begin
                        work_seq_q   <= pkt_seq_num + SEQ_W'(pkt_payload_len);
                        cnt_q        <= cnt_inc;
                        avail_left_q <= avail_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb                = (state == S_WB);
    assign sched_req_rdy     = rdy_q;
    assign state_rd_req_val  = (state == S_RD);
    assign state_rd_req_addr = flowid_q;
    assign pkt_val           = (state == S_EMIT);
    assign pkt_flowid        = flowid_q;
    assign seq_wr_val        = wb;
    assign seq_wr_addr       = flowid_q;
    // A retransmit rewinds below the stored sequence; never write that regression back.
    assign seq_wr_data       = !wb ? '0 :
                               ($signed(work_seq_q - orig_seq_q) < 0) ? orig_seq_q : work_seq_q;
    assign upd_val           = wb;
    assign upd_flowid        = flowid_q;
    assign upd_rt_clear      = wb & rt_q;
    assign upd_ack_clear     = wb & ack_q & (cnt_q != '0);
    assign upd_data_clear    = wb & (avail_left_q == '0);

endmodule

// File: tb/tb_tcp_tx_burst_datap.sv
// tb/tb_tcp_tx_burst_datap.sv - scoreboard bench for tcp_tx_burst_datap
module tb_tcp_tx_burst_datap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sched_req_val = 1'b0;
    logic        sched_req_rdy;
    logic [7:0]  sched_req_flowid = '0;
    logic        sched_req_rt = 1'b0;
    logic        sched_req_ack = 1'b0;
    logic        state_rd_req_val;
    logic [7:0]  state_rd_req_addr;
    logic [16:0] state_rd_resp_tail = '0;
    logic [31:0] state_rd_resp_seq = '0;
    logic [31:0] state_rd_resp_acked = '0;
    logic [31:0] state_rd_resp_their_ack = '0;
    logic [15:0] state_rd_resp_their_win = '0;
    logic [15:0] state_rd_resp_our_win = '0;
    logic        seq_wr_val;
    logic [7:0]  seq_wr_addr;
    logic [31:0] seq_wr_data;
    logic        pkt_val;
    logic        pkt_rdy = 1'b1;
    logic [7:0]  pkt_flowid;
    logic [31:0] pkt_seq_num, pkt_ack_num;
    logic [15:0] pkt_win;
    logic [7:0]  pkt_flags;
    logic [15:0] pkt_payload_addr;
    logic [16:0] pkt_payload_len;
    logic        upd_val, upd_flowid_dummy;
    logic [7:0]  upd_flowid;
    logic        upd_rt_clear, upd_ack_clear, upd_data_clear;

    tcp_tx_burst_datap dut (
        .clk(clk), .rst_n(rst_n),
        .sched_req_val(sched_req_val), .sched_req_rdy(sched_req_rdy),
        .sched_req_flowid(sched_req_flowid), .sched_req_rt(sched_req_rt), .sched_req_ack(sched_req_ack),
        .state_rd_req_val(state_rd_req_val), .state_rd_req_addr(state_rd_req_addr),
        .state_rd_resp_tail(state_rd_resp_tail), .state_rd_resp_seq(state_rd_resp_seq),
        .state_rd_resp_acked(state_rd_resp_acked), .state_rd_resp_their_ack(state_rd_resp_their_ack),
        .state_rd_resp_their_win(state_rd_resp_their_win), .state_rd_resp_our_win(state_rd_resp_our_win),
        .seq_wr_val(seq_wr_val), .seq_wr_addr(seq_wr_addr), .seq_wr_data(seq_wr_data),
        .pkt_val(pkt_val), .pkt_rdy(pkt_rdy), .pkt_flowid(pkt_flowid),
        .pkt_seq_num(pkt_seq_num), .pkt_ack_num(pkt_ack_num), .pkt_win(pkt_win),
        .pkt_flags(pkt_flags), .pkt_payload_addr(pkt_payload_addr), .pkt_payload_len(pkt_payload_len),
        .upd_val(upd_val), .upd_flowid(upd_flowid), .upd_rt_clear(upd_rt_clear),
        .upd_ack_clear(upd_ack_clear), .upd_data_clear(upd_data_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] seq;
        logic [16:0] len;
        logic [7:0]  flags;
        int          gap;
    } pkt_t;

    typedef struct {
        logic [31:0] data;
        logic        rt;
        logic        ack;
        logic        dclr;
        int          gap;
    } wb_t;

    pkt_t exp_pkt[$];
    wb_t  exp_wb[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_hs_cyc = 0;
    int wb_cnt = 0;
    int wb_target = 0;
    logic        rdy_chk = 1'b0;
    logic [7:0]  g_flowid = '0;
    logic [31:0] g_their_ack = '0;
    logic [15:0] g_our_win = '0;

    assign upd_flowid_dummy = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Output monitor: sampled on the falling edge, pops the scoreboard on each handshake.
    initial begin
        pkt_t p;
        wb_t  w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rdy_chk) begin
                    rdy_chk = 1'b0;
                    vectors++;
                    if (sched_req_rdy !== 1'b1) begin
                        miscompares++;
                        $display("FAIL rdy_after_wb: got %b want 1", sched_req_rdy);
                    end
                end
                if (pkt_val && pkt_rdy) begin
                    vectors++;
                    if (exp_pkt.size() == 0) begin
                        miscompares++;
                        $display("FAIL pkt_unexpected: got seq %0h len %0d want no segment", pkt_seq_num, pkt_payload_len);
                    end else begin
                        p = exp_pkt.pop_front();
                        if (pkt_seq_num !== p.seq) begin
                            miscompares++;
                            $display("FAIL pkt_seq: got %0h want %0h", pkt_seq_num, p.seq);
                        end
                        vectors++;
                        if (pkt_payload_len !== p.len) begin
                            miscompares++;
                            $display("FAIL pkt_len: got %0d want %0d", pkt_payload_len, p.len);
                        end
                        vectors++;
                        if (pkt_payload_addr !== p.seq[15:0]) begin
                            miscompares++;
                            $display("FAIL pkt_addr: got %0h want %0h", pkt_payload_addr, p.seq[15:0]);
                        end
                        vectors++;
                        if (pkt_flags !== p.flags) begin
                            miscompares++;
                            $display("FAIL pkt_flags: got %0h want %0h", pkt_flags, p.flags);
                        end
                        vectors++;
                        if (pkt_ack_num !== g_their_ack || pkt_win !== g_our_win || pkt_flowid !== g_flowid) begin
                            miscompares++;
                            $display("FAIL pkt_hdr: got ack %0h win %0h fid %0h want %0h %0h %0h",
                                     pkt_ack_num, pkt_win, pkt_flowid, g_their_ack, g_our_win, g_flowid);
                        end
                        if (p.gap != 0) begin
                            vectors++;
                            if (cyc - last_hs_cyc != p.gap) begin
                                miscompares++;
                                $display("FAIL pkt_timing: got gap %0d want %0d", cyc - last_hs_cyc, p.gap);
                            end
                        end
                    end
                    last_hs_cyc = cyc;
                end
                if (seq_wr_val || upd_val) begin
                    wb_cnt++;
                    rdy_chk = 1'b1;
                    vectors++;
                    if (exp_wb.size() == 0) begin
                        miscompares++;
                        $display("FAIL wb_unexpected: got seq_wr %b upd %b want none", seq_wr_val, upd_val);
                    end else begin
                        w = exp_wb.pop_front();
                        if (seq_wr_val !== 1'b1 || upd_val !== 1'b1) begin
                            miscompares++;
                            $display("FAIL wb_pair: got seq_wr %b upd %b want 1 1", seq_wr_val, upd_val);
                        end
                        vectors++;
                        if (seq_wr_data !== w.data) begin
                            miscompares++;
                            $display("FAIL wb_seq: got %0h want %0h", seq_wr_data, w.data);
                        end
                        vectors++;
                        if (seq_wr_addr !== g_flowid || upd_flowid !== g_flowid) begin
                            miscompares++;
                            $display("FAIL wb_flowid: got %0h %0h want %0h", seq_wr_addr, upd_flowid, g_flowid);
                        end
                        vectors++;
                        if ({upd_rt_clear, upd_ack_clear, upd_data_clear} !== {w.rt, w.ack, w.dclr}) begin
                            miscompares++;
                            $display("FAIL wb_clear: got %b%b%b want %b%b%b", upd_rt_clear, upd_ack_clear,
                                     upd_data_clear, w.rt, w.ack, w.dclr);
                        end
                        vectors++;
                        if (cyc - last_hs_cyc != w.gap) begin
                            miscompares++;
                            $display("FAIL wb_timing: got gap %0d want %0d", cyc - last_hs_cyc, w.gap);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_pkt(input logic [31:0] seq, input logic [16:0] len, input logic [7:0] flags, input int gap);
        pkt_t p;
        p.seq = seq; p.len = len; p.flags = flags; p.gap = gap;
        exp_pkt.push_back(p);
    endtask

    task automatic push_wb(input logic [31:0] data, input logic rt, input logic ack, input logic dclr, input int gap);
        wb_t w;
        w.data = data; w.rt = rt; w.ack = ack; w.dclr = dclr; w.gap = gap;
        exp_wb.push_back(w);
    endtask

    task automatic set_state(input logic [16:0] tail, input logic [31:0] seq, input logic [31:0] acked,
                             input logic [15:0] their_win);
        g_their_ack = $urandom;
        g_our_win   = 16'($urandom);
        state_rd_resp_tail      = tail;
        state_rd_resp_seq       = seq;
        state_rd_resp_acked     = acked;
        state_rd_resp_their_ack = g_their_ack;
        state_rd_resp_their_win = their_win;
        state_rd_resp_our_win   = g_our_win;
    endtask

    // Issues one grant; the read response is scrambled once CALC has consumed it.
    task automatic grant(input logic [7:0] fid, input logic rt, input logic ack);
        int n = 0;
        g_flowid = fid;
        @(negedge clk);
        sched_req_val = 1'b1; sched_req_flowid = fid; sched_req_rt = rt; sched_req_ack = ack;
        while (sched_req_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sched_req_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL grant_rdy: got %b want 1", sched_req_rdy);
        end
        accept_cyc  = cyc;
        last_hs_cyc = cyc;
        @(negedge clk);
        sched_req_val = 1'b0;
        vectors++;
        if (state_rd_req_val !== 1'b1 || state_rd_req_addr !== fid || sched_req_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_req: got val %b addr %0h rdy %b want 1 %0h 0", state_rd_req_val,
                     state_rd_req_addr, sched_req_rdy, fid);
        end
        @(negedge clk);
        vectors++;
        if (state_rd_req_val !== 1'b0 || pkt_val !== 1'b0) begin
            miscompares++;
            $display("FAIL calc_cycle: got rd_val %b pkt_val %b want 0 0", state_rd_req_val, pkt_val);
        end
        @(negedge clk);
        state_rd_resp_tail = 17'($urandom); state_rd_resp_seq = $urandom; state_rd_resp_acked = $urandom;
        state_rd_resp_their_ack = $urandom; state_rd_resp_their_win = 16'($urandom);
        state_rd_resp_our_win = 16'($urandom);
    endtask

    task automatic wait_wb();
        int n = 0;
        wb_target++;
        while (wb_cnt < wb_target && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (wb_cnt < wb_target) begin
            miscompares++;
            $display("FAIL wb_timeout: got %0d writebacks want %0d", wb_cnt, wb_target);
            wb_target = wb_cnt;
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_pkt.size() != 0 || exp_wb.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d pkts %0d wbs pending want 0 0", exp_pkt.size(), exp_wb.size());
        end
        exp_pkt.delete();
        exp_wb.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({sched_req_rdy, state_rd_req_val, pkt_val, seq_wr_val, upd_val} !== 5'b0 ||
            pkt_seq_num !== 32'h0 || pkt_payload_len !== 17'h0 || seq_wr_data !== 32'h0 || pkt_flags !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy %b pkt_val %b seq %0h len %0d want all 0",
                     sched_req_rdy, pkt_val, pkt_seq_num, pkt_payload_len);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (sched_req_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL rdy_before_clock: got %b want 0", sched_req_rdy);
        end
        @(negedge clk);
        vectors++;
        if (sched_req_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL rdy_after_release: got %b want 1", sched_req_rdy);
        end
    endtask

    task automatic test_new_data();
        push_pkt(32'd1000, 17'd1460, 8'h18, 3);
        push_pkt(32'd2460, 17'd1460, 8'h18, 2);
        push_pkt(32'd3920, 17'd1460, 8'h18, 2);
        push_pkt(32'd5380, 17'd620,  8'h18, 2);
        push_wb(32'd6000, 1'b0, 1'b1, 1'b1, 1);
        set_state(17'd6000, 32'd1000, 32'd1000, 16'hFFFF);
        grant(8'h11, 1'b0, 1'b1);
        wait_wb();
    endtask

    task automatic test_max_burst();
        push_pkt(32'd1000, 17'd1460, 8'h18, 3);
        push_pkt(32'd2460, 17'd1460, 8'h18, 2);
        push_pkt(32'd3920, 17'd1460, 8'h18, 2);
        push_pkt(32'd5380, 17'd1460, 8'h18, 2);
        push_wb(32'd6840, 1'b0, 1'b0, 1'b0, 1);
        set_state(17'd9000, 32'd1000, 32'd1000, 16'hFFFF);
        grant(8'h22, 1'b0, 1'b0);
        wait_wb();
    endtask

    task automatic test_retransmit();
        push_pkt(32'd1000, 17'd1460, 8'h18, 3);
        push_wb(32'd3000, 1'b1, 1'b0, 1'b0, 1);
        set_state(17'd6000, 32'd3000, 32'd1000, 16'hFFFF);
        grant(8'h33, 1'b1, 1'b0);
        wait_wb();
    endtask

    task automatic test_window_limit();
        push_pkt(32'd1000, 17'd1000, 8'h18, 3);
        push_wb(32'd2000, 1'b0, 1'b0, 1'b0, 2);
        set_state(17'd6000, 32'd1000, 32'd1000, 16'd1000);
        grant(8'h44, 1'b0, 1'b0);
        wait_wb();
    endtask

    task automatic test_zero_window(input logic ack);
`ifdef TCP_TX_ZWP_EN
        push_pkt(32'd1000, 17'd1, 8'h18, 3);
        push_wb(32'd1001, 1'b0, ack, 1'b0, 2);
`else
        if (ack) begin
            push_pkt(32'd1000, 17'd0, 8'h10, 3);
            push_wb(32'd1000, 1'b0, 1'b1, 1'b0, 1);
        end else begin
            push_wb(32'd1000, 1'b0, 1'b0, 1'b0, 3);
        end
`endif
        set_state(17'd1100, 32'd1000, 32'd1000, 16'd0);
        grant(8'h55, 1'b0, ack);
        wait_wb();
    endtask

    task automatic test_seq_wrap();
        push_pkt(32'hFFFF_FF00, 17'd512, 8'h18, 3);
        push_wb(32'h0000_0100, 1'b0, 1'b0, 1'b1, 1);
        set_state(17'h00100, 32'hFFFF_FF00, 32'hFFFF_FF00, 16'hFFFF);
        grant(8'h66, 1'b0, 1'b0);
        wait_wb();
    endtask

    task automatic test_stall_reset();
        int n = 0;
        @(posedge clk); #1 pkt_rdy = 1'b0;
        push_pkt(32'd1000, 17'd1460, 8'h18, 0);
        set_state(17'd6000, 32'd1000, 32'd1000, 16'hFFFF);
        grant(8'h77, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (pkt_val !== 1'b1 || pkt_seq_num !== 32'd1000 || pkt_payload_len !== 17'd1460 ||
                pkt_flags !== 8'h18 || pkt_payload_addr !== 16'd1000) begin
                miscompares++;
                $display("FAIL stall_hold: got val %b seq %0d len %0d flags %0h want 1 1000 1460 18",
                         pkt_val, pkt_seq_num, pkt_payload_len, pkt_flags);
            end
            @(negedge clk);
        end
        @(posedge clk); #1 pkt_rdy = 1'b1;
        @(posedge clk); #1 pkt_rdy = 1'b0;
        @(negedge clk);
        vectors++;
        if (pkt_val !== 1'b0) begin
            miscompares++;
            $display("FAIL calc_gap: got pkt_val %b want 0", pkt_val);
        end
        @(negedge clk);
        vectors++;
        if (pkt_val !== 1'b1 || pkt_seq_num !== 32'd2460) begin
            miscompares++;
            $display("FAIL second_seg: got val %b seq %0d want 1 2460", pkt_val, pkt_seq_num);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (pkt_val !== 1'b0) begin
            miscompares++;
            $display("FAIL async_abort: got pkt_val %b want 0", pkt_val);
        end
        repeat (3) begin
            @(negedge clk);
            if (seq_wr_val || upd_val) n++;
        end
        rst_n = 1'b1;
        pkt_rdy = 1'b1;
        rdy_chk = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (seq_wr_val || upd_val) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL abort_no_wb: got %0d writeback cycles want 0", n);
        end
        vectors++;
        if (sched_req_rdy !== 1'b1 || exp_pkt.size() != 0) begin
            miscompares++;
            $display("FAIL rdy_after_abort: got rdy %b pending %0d want 1 0", sched_req_rdy, exp_pkt.size());
        end
        exp_pkt.delete();
        exp_wb.delete();
    endtask

    initial begin
        test_reset();
        test_new_data();
        test_max_burst();
        test_retransmit();
        test_window_limit();
        test_zero_window(1'b1);
        test_zero_window(1'b0);
        test_seq_wrap();
        test_stall_reset();
        test_new_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
